// File: rtl/gpr_wport_arb.sv
// GPR write-port arbiter: pipeline writeback has fixed priority, MDU results queue and drain into idle slots.
// Latency: wb write 1 cycle; MDU write >= 2 cycles (push, then pop into the output register).
// Backpressure: md_ready = !full; stall_req forces an idle wb slot after STARVE_MAX blocked cycles.
module gpr_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_req,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        busy_rs,
    output logic        busy_rt,
    output logic        stall_req,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        err_waw
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    // Result FIFO storage and control
    logic [4:0]       fifo_addr_q [DEPTH];
    logic [4:0]       fifo_addr_d [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q;
    logic [DEPTH-1:0] fifo_vld_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Output register
    logic             gpr_we_q;
    logic             gpr_we_d;
    logic [4:0]       gpr_waddr_q;
    logic [4:0]       gpr_waddr_d;
    logic [31:0]      gpr_wdata_q;
    logic [31:0]      gpr_wdata_d;
    logic             out_md_q;
    logic             out_md_d;

    // Starvation tracking and error flag
    state_t           state_q;
    state_t           state_d;
    logic [SW-1:0]    starve_cnt_q;
    logic [SW-1:0]    starve_cnt_d;
    logic             stall_req_q;
    logic             stall_req_d;
    logic             err_waw_q;
    logic             err_waw_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             blocked;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;
    logic             rs_hit;
    logic             rt_hit;
    logic             wb_hit;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign md_ready   = !fifo_full;
    // r0 results are accepted on the handshake but dropped, since they never write
    assign push       = md_req && md_ready && (md_addr != 5'd0);
    assign pop        = !wb_we && !fifo_empty;
    assign blocked    = wb_we && !fifo_empty;
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        wb_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[i] && (fifo_addr_q[i] == rs_addr)) rs_hit = 1'b1;
            if (fifo_vld_q[i] && (fifo_addr_q[i] == rt_addr)) rt_hit = 1'b1;
            if (fifo_vld_q[i] && (fifo_addr_q[i] == wb_addr)) wb_hit = 1'b1;
        end
    end

    // An MDU result is still pending while it sits in the output register
    assign busy_rs = (rs_addr != 5'd0) && (rs_hit || (out_md_q && (gpr_waddr_q == rs_addr)));
    assign busy_rt = (rt_addr != 5'd0) && (rt_hit || (out_md_q && (gpr_waddr_q == rt_addr)));

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = md_addr;
            fifo_data_d[wr_ptr_q] = md_data;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        gpr_we_d    = 1'b0;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        out_md_d    = 1'b0;
        if (wb_we) begin
            gpr_we_d    = (wb_addr != 5'd0);
            gpr_waddr_d = wb_addr;
            gpr_wdata_d = wb_data;
        end else if (pop) begin
            gpr_we_d    = (head_addr != 5'd0);
            gpr_waddr_d = head_addr;
            gpr_wdata_d = head_data;
            out_md_d    = 1'b1;
        end
    end

    assign err_waw_d = err_waw_q || (wb_we && (wb_addr != 5'd0) && wb_hit);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        stall_req_d  = stall_req_q;
        if (fifo_empty) begin
            state_d      = ST_RUN;
            starve_cnt_d = '0;
            stall_req_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    stall_req_d = 1'b0;
                    if (blocked) begin
                        if (starve_cnt_q == SW'(STARVE_MAX - 1)) begin
                            state_d     = ST_FORCE;
                            stall_req_d = 1'b1;
                        end else begin
                            starve_cnt_d = starve_cnt_q + SW'(1);
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
                ST_FORCE: begin
                    stall_req_d = 1'b1;
                    // wb keeps priority; the first idle slot drains the head
                    if (!wb_we) begin
                        state_d      = ST_RUN;
                        starve_cnt_d = '0;
                        stall_req_d  = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_RUN;
                    starve_cnt_d = '0;
                    stall_req_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_vld_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gpr_we_q     <= 1'b0;
            gpr_waddr_q  <= 5'd0;
            gpr_wdata_q  <= 32'd0;
            out_md_q     <= 1'b0;
            state_q      <= ST_RUN;
            starve_cnt_q <= '0;
            stall_req_q  <= 1'b0;
            err_waw_q    <= 1'b0;
        end else begin
            fifo_vld_q   <= fifo_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            gpr_we_q     <= gpr_we_d;
            gpr_waddr_q  <= gpr_waddr_d;
            gpr_wdata_q  <= gpr_wdata_d;
            out_md_q     <= out_md_d;
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stall_req_q  <= stall_req_d;
            err_waw_q    <= err_waw_d;
        end
    end

    assign gpr_we    = gpr_we_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;
    assign stall_req = stall_req_q;
    assign err_waw   = err_waw_q;

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Bench for gpr_wport_arb: expected GPR writes (addr, data, cycle) go into a scoreboard
// queue; a negedge monitor matches every gpr_we pulse against it.
module tb_gpr_wport_arb;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_req;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        busy_rs;
    logic        busy_rt;
    logic        stall_req;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        err_waw;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    gpr_wport_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .md_req    (md_req),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .busy_rs   (busy_rs),
        .busy_rt   (busy_rt),
        .stall_req (stall_req),
        .gpr_we    (gpr_we),
        .gpr_waddr (gpr_waddr),
        .gpr_wdata (gpr_wdata),
        .err_waw   (err_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mr, input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        wb_we   = we;
        wb_addr = wa;
        wb_data = wd;
        md_req  = mr;
        md_addr = ma;
        md_data = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        sb.push_back('{a: a, d: d, c: c});
    endtask

    // Monitor: every write must match the queue head in address, data and cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (sb.size() > 0 && sb[0].c < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_write: addr %0d data %0h due cycle %0d, not seen by %0d",
                             sb[0].a, sb[0].d, sb[0].c, cyc);
                    void'(sb.pop_front());
                end
                if (gpr_we) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0h cycle %0d, none expected",
                                 gpr_waddr, gpr_wdata, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        if (gpr_waddr !== mon_e.a || gpr_wdata !== mon_e.d || cyc != mon_e.c) begin
                            errors++;
                            $display("FAIL gpr_write: got addr %0d data %0h cycle %0d, expected addr %0d data %0h cycle %0d",
                                     gpr_waddr, gpr_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        wb_we   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        md_req  = 1'b0;
        md_addr = 5'd0;
        md_data = 32'd0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_gpr_we", 32'(gpr_we), 32'd0);
        chk("rst_gpr_waddr", 32'(gpr_waddr), 32'd0);
        chk("rst_gpr_wdata", gpr_wdata, 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd1);
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        chk("rst_err_waw", 32'(err_waw), 32'd0);

        // wb only, then a wb write to r0
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'h1234, cyc + 1);
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
        idle();
        #1 chk("wb_r0_no_we", 32'(gpr_we), 32'd0);

        // MDU push to r0 is dropped; then a normal drain to r8
        rs_addr = 5'd8;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        #1 chk("md_r0_ready", 32'(md_ready), 32'd1);
        idle();
        idle();
        #1 chk("md_r0_dropped", 32'(gpr_we), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD);
        expect_wr(5'd8, 32'hDEAD, cyc + 2);
        idle();
        #1 chk("drain_busy_fifo", 32'(busy_rs), 32'd1);
        idle();
        #1 chk("drain_busy_outreg", 32'(busy_rs), 32'd1);
        idle();
        #1 chk("drain_busy_clear", 32'(busy_rs), 32'd0);

        // Fill the FIFO behind continuous wb traffic
        rt_addr = 5'd11;
        rs_addr = 5'd12;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd3, 32'h33, cyc + 1);
        #1 chk("full_ready_0", 32'(md_ready), 32'd1);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hA1);
        expect_wr(5'd4, 32'h44, cyc + 1);
        #1 chk("full_ready_1", 32'(md_ready), 32'd1);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hA2);
        expect_wr(5'd6, 32'h66, cyc + 1);
        #1 chk("full_ready_2", 32'(md_ready), 32'd0);
        chk("full_busy_rt", 32'(busy_rt), 32'd1);
        idle();
        expect_wr(5'd10, 32'hA0, cyc + 1);
        #1 chk("full_third_rejected", 32'(busy_rs), 32'd0);
        chk("waw_clear_before", 32'(err_waw), 32'd0);
        idle();
        expect_wr(5'd11, 32'hA1, cyc + 1);
        idle();
        #1 chk("full_busy_rt_out", 32'(busy_rt), 32'd1);
        chk("full_ready_back", 32'(md_ready), 32'd1);
        idle();
        #1 chk("full_busy_rt_clear", 32'(busy_rt), 32'd0);

        // Starvation: 4 blocked cycles raise stall_req
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(20 + i), 32'(32'h200 + i), 1'b0, 5'd0, 32'd0);
            expect_wr(5'(20 + i), 32'(32'h200 + i), cyc + 1);
        end
        #1 chk("starve_not_yet", 32'(stall_req), 32'd0);
        drive(1'b1, 5'd24, 32'h240, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd24, 32'h240, cyc + 1);
        #1 chk("starve_stall", 32'(stall_req), 32'd1);
        idle();
        expect_wr(5'd13, 32'hB0, cyc + 1);
        #1 chk("starve_hold_in_force", 32'(stall_req), 32'd1);
        idle();
        #1 chk("starve_released", 32'(stall_req), 32'd0);

        // WAW: wb writes r9 while an MDU r9 result is queued
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hC0);
        drive(1'b1, 5'd9, 32'hC1, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'hC1, cyc + 1);
        #1 chk("waw_not_yet", 32'(err_waw), 32'd0);
        idle();
        expect_wr(5'd9, 32'hC0, cyc + 1);
        #1 chk("waw_set", 32'(err_waw), 32'd1);
        idle();
        idle();
        #1 chk("waw_sticky", 32'(err_waw), 32'd1);

        // Reset mid-stream with two results queued
        rs_addr = 5'd14;
        rt_addr = 5'd15;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hD0);
        expect_wr(5'd1, 32'h1, cyc + 1);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd15, 32'hD1);
        expect_wr(5'd2, 32'h2, cyc + 1);
        idle();
        #1 chk("pre_rst_full", 32'(md_ready), 32'd0);
        chk("pre_rst_busy_rs", 32'(busy_rs), 32'd1);
        #1 rst = 1'b1;
        #1 chk("mid_rst_gpr_we", 32'(gpr_we), 32'd0);
        chk("mid_rst_md_ready", 32'(md_ready), 32'd1);
        chk("mid_rst_busy_rs", 32'(busy_rs), 32'd0);
        chk("mid_rst_busy_rt", 32'(busy_rt), 32'd0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        chk("mid_rst_err_waw", 32'(err_waw), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) idle();
        #1 chk("post_rst_busy_rt", 32'(busy_rt), 32'd0);

        // FIFO works normally after reset
        drive(1'b0, 5'd7, 32'd0, 1'b1, 5'd7, 32'hE0);
        expect_wr(5'd7, 32'hE0, cyc + 2);
        repeat (4) idle();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
